power_domain_sequencer: RTL and testbench
=========================================

// Module: power_domain_sequencer
// PURPOSE
//  Consumes the power state from the power state machine and sequences the compute domain's physical controls.
//  Controls driven: clock gate, isolation, retention save/restore, power switch.
//  IDLE/SLEEP gate the clock; DEEP_SLEEP powers the domain down with state retention; THERMAL_THROTTLE runs with throttle.
//  Sits between the power state machine and the clock-gate / power-switch cells.
// PARAMETERS
//  ISO_CYCLES      2    dwell cycles for isolation setup (ISO) and for isolation hold before release (DEISO); >=1
//  SAVE_CYCLES     4    cycles ret_save_o is held high; >=1
//  RESTORE_CYCLES  4    cycles ret_restore_o is held high; >=1
//  ACK_TIMEOUT     256  max cycles spent waiting for pwr_sw_ack_i; >=1
// PORTS
//  clk_i             in   1   clock
//  rst_i             in   1   synchronous reset, active-high
//  target_state_i    in   power_state_t  current_power_state_o from the power state machine
//  pwr_sw_ack_i      in   1   power-switch chain status (1 = domain powered)
//  err_clr_i         in   1   clears ack_timeout_err_o
//  clk_en_o          out  1   domain clock-gate enable
//  iso_en_o          out  1   output isolation enable
//  ret_save_o        out  1   retention save strobe (level, SAVE_CYCLES long)
//  ret_restore_o     out  1   retention restore strobe (level, RESTORE_CYCLES long)
//  pwr_sw_en_o       out  1   power-switch enable
//  throttle_o        out  1   clock throttle request
//  wake_done_o       out  1   1-cycle pulse on entry to ON from GATED
//  busy_o            out  1   a non-abortable sequence is in progress
//  ack_timeout_err_o out  1   sticky: a power-switch ack wait timed out
//  seq_state_o       out  4   state: ON=0 GATED=1 ISO=2 SAVE=3 PSW_OFF=4 OFF=5 PSW_ON=6 RESTORE=7 DEISO=8
// BEHAVIOUR
//  Single clock clk_i; rst_i synchronous, active-high. All outputs are Moore decodes of registered state, except throttle_o, which is a register.
//  Reset: state ON.
//    - clk_en=1, pwr_sw_en=1, all other outputs 0.
//    - Dwell counter and ack counter = 0.
//    - rst_i during any state returns the block to ON on the next edge.
//  Per-state outputs (clk_en, iso, save, restore, psw):
//    ON 1,0,0,0,1 | GATED 0,0,0,0,1 | ISO 0,1,0,0,1 | SAVE 0,1,1,0,1 | PSW_OFF 0,1,0,0,0
//    OFF 0,1,0,0,0 | PSW_ON 0,1,0,0,1 | RESTORE 0,1,0,1,1 | DEISO 0,1,0,0,1
//  busy_o=1 in ISO, SAVE, PSW_OFF, PSW_ON, RESTORE, DEISO.
//  target_state_i is sampled only in ON, GATED and OFF; all other states run to completion regardless of target.
//  Transitions:
//  - ON:      target IDLE/SLEEP/DEEP_SLEEP -> GATED; ACTIVE/THROTTLE -> stay.
//  - GATED:   ACTIVE/THROTTLE -> ON (wake_done_o=1 in first ON cycle); DEEP_SLEEP -> ISO; IDLE/SLEEP -> stay.
//  - ISO:     after exactly ISO_CYCLES cycles -> SAVE.
//  - SAVE:    after exactly SAVE_CYCLES cycles -> PSW_OFF.
//  - PSW_OFF: when pwr_sw_ack_i==0 -> OFF.
//  - OFF:     target != DEEP_SLEEP -> PSW_ON.
//  - PSW_ON:  when pwr_sw_ack_i==1 -> RESTORE.
//  - RESTORE: after exactly RESTORE_CYCLES cycles -> DEISO.
//  - DEISO:   after exactly ISO_CYCLES cycles -> GATED; GATED then re-evaluates the target.
//  Ack waits (PSW_OFF, PSW_ON):
//  - Ack counter clears on state entry.
//  - If the expected ack value is present in the same cycle the counter reaches ACK_TIMEOUT, the ack wins and no error is flagged.
//  - If the counter reaches ACK_TIMEOUT without the expected ack: set ack_timeout_err_o and advance as if acked.
//  Dwell counter clears on every state change; width $clog2(max param)+1, no wrap.
//  ack_timeout_err_o:
//  - Cleared by rst_i or err_clr_i.
//  - A set and err_clr_i in the same cycle leaves it set.
//  throttle_o <= (state==ON && target==THERMAL_THROTTLE); otherwise 0.
//  Latency:
//  - Target IDLE sampled in ON at edge k -> clk_en_o=0 from edge k.
//  - Minimum ON->OFF path: 1 + ISO_CYCLES + SAVE_CYCLES + ack-wait cycles.
// TESTING
//  1. Assert rst_i 2 cycles -> clk_en=1, psw=1, iso/save/restore/throttle/busy/err=0, seq_state=0.
//  2. ACTIVE->IDLE for 5 cycles, then ACTIVE -> clk_en 0 one edge after IDLE; back to 1 one edge after ACTIVE; wake_done exactly 1 cycle.
//  3. ACTIVE->DEEP_SLEEP, ack drops 3 cycles after psw=0 -> iso high 2 cycles before save; save high exactly 4 cycles; OFF reached; busy=0.
//  4. From OFF set ACTIVE, ack rises after 5 cycles -> restore high 4 cycles, DEISO 2 cycles, iso falls, GATED, ON, clk_en=1, wake_done pulse.
//  5. ACK_TIMEOUT=16, ack held high in PSW_OFF:
//     - err rises after 16 cycles and state advances to OFF.
//     - err_clr_i clears err.
//     - rst_i mid-PSW_ON -> state ON next edge.
//  6. Target ACTIVE during SAVE -> sequence completes to OFF, then PSW_ON next edge; THERMAL_THROTTLE in ON -> throttle_o=1 one edge later.

Source files
------------

// File: rtl/power_domain_sequencer.sv
// Compute-domain power sequencer: turns the power state requested by the
// power state machine into clock-gate, isolation, retention and power-switch
// controls, walking the domain through a fixed save/off/restore sequence.

package power_domain_sequencer_pkg;
    typedef enum logic [2:0] {
        PWR_ACTIVE           = 3'd0,
        PWR_IDLE             = 3'd1,
        PWR_SLEEP            = 3'd2,
        PWR_DEEP_SLEEP       = 3'd3,
        PWR_THERMAL_THROTTLE = 3'd4
    } power_state_t;
endpackage

module power_domain_sequencer
    import power_domain_sequencer_pkg::*;
#(
    parameter int unsigned ISO_CYCLES     = 2,
    parameter int unsigned SAVE_CYCLES    = 4,
    parameter int unsigned RESTORE_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT    = 256
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  power_state_t target_state_i,
    input  logic         pwr_sw_ack_i,
    input  logic         err_clr_i,
    output logic         clk_en_o,
    output logic         iso_en_o,
    output logic         ret_save_o,
    output logic         ret_restore_o,
    output logic         pwr_sw_en_o,
    output logic         throttle_o,
    output logic         wake_done_o,
    output logic         busy_o,
    output logic         ack_timeout_err_o,
    output logic [3:0]   seq_state_o
);

    typedef enum logic [3:0] {
        ST_ON      = 4'd0,
        ST_GATED   = 4'd1,
        ST_ISO     = 4'd2,
        ST_SAVE    = 4'd3,
        ST_PSW_OFF = 4'd4,
        ST_OFF     = 4'd5,
        ST_PSW_ON  = 4'd6,
        ST_RESTORE = 4'd7,
        ST_DEISO   = 4'd8
    } seq_state_t;

    localparam int unsigned DWELL_MAX_A = (ISO_CYCLES > SAVE_CYCLES) ? ISO_CYCLES : SAVE_CYCLES;
    localparam int unsigned DWELL_MAX   = (DWELL_MAX_A > RESTORE_CYCLES) ? DWELL_MAX_A : RESTORE_CYCLES;
    localparam int unsigned DW          = $clog2(DWELL_MAX) + 1;
    localparam int unsigned AW          = $clog2(ACK_TIMEOUT) + 1;

    // Counters hold the number of cycles already spent in the state, so the
    // last cycle of a dwell is the one where the count equals N-1.
    localparam logic [DW-1:0] ISO_LAST     = DW'(ISO_CYCLES - 1);
    localparam logic [DW-1:0] SAVE_LAST    = DW'(SAVE_CYCLES - 1);
    localparam logic [DW-1:0] RESTORE_LAST = DW'(RESTORE_CYCLES - 1);
    localparam logic [AW-1:0] ACK_LAST     = AW'(ACK_TIMEOUT - 1);

    seq_state_t    state_reg, state_next;
    logic [DW-1:0] dwell_reg, dwell_next;
    logic [AW-1:0] ack_cnt_reg, ack_cnt_next;
    logic          err_reg, err_next;
    logic          throttle_reg, throttle_next;
    logic          wake_done_reg, wake_done_next;
    logic          ack_timeout_set;
    logic          in_ack_wait;

    // Next-state logic; target is only looked at in ON, GATED and OFF.
    always_comb begin
        state_next      = state_reg;
        ack_timeout_set = 1'b0;
        case (state_reg)
            ST_ON: begin
                if (target_state_i == PWR_IDLE || target_state_i == PWR_SLEEP ||
                    target_state_i == PWR_DEEP_SLEEP)
                    state_next = ST_GATED;
            end
            ST_GATED: begin
                if (target_state_i == PWR_ACTIVE || target_state_i == PWR_THERMAL_THROTTLE)
                    state_next = ST_ON;
                else if (target_state_i == PWR_DEEP_SLEEP)
                    state_next = ST_ISO;
            end
            ST_ISO: begin
                if (dwell_reg == ISO_LAST) state_next = ST_SAVE;
            end
            ST_SAVE: begin
                if (dwell_reg == SAVE_LAST) state_next = ST_PSW_OFF;
            end
            ST_PSW_OFF: begin
                // A real ack on the final wait cycle takes priority over the timeout.
                if (!pwr_sw_ack_i) begin
                    state_next = ST_OFF;
                end else if (ack_cnt_reg == ACK_LAST) begin
                    state_next      = ST_OFF;
                    ack_timeout_set = 1'b1;
                end
            end
            ST_OFF: begin
                if (target_state_i != PWR_DEEP_SLEEP) state_next = ST_PSW_ON;
            end
            ST_PSW_ON: begin
                if (pwr_sw_ack_i) begin
                    state_next = ST_RESTORE;
                end else if (ack_cnt_reg == ACK_LAST) begin
                    state_next      = ST_RESTORE;
                    ack_timeout_set = 1'b1;
                end
            end
            ST_RESTORE: begin
                if (dwell_reg == RESTORE_LAST) state_next = ST_DEISO;
            end
            ST_DEISO: begin
                if (dwell_reg == ISO_LAST) state_next = ST_GATED;
            end
            default: state_next = ST_ON;
        endcase
    end

    // Counter, error-flag and registered-output next values.
    always_comb begin
        in_ack_wait = (state_reg == ST_PSW_OFF) || (state_reg == ST_PSW_ON);
        if (state_next != state_reg)
            dwell_next = '0;
        else if (dwell_reg != '1)
            dwell_next = dwell_reg + DW'(1);
        else
            dwell_next = dwell_reg;

        if (state_next != state_reg || !in_ack_wait)
            ack_cnt_next = '0;
        else if (ack_cnt_reg != '1)
            ack_cnt_next = ack_cnt_reg + AW'(1);
        else
            ack_cnt_next = ack_cnt_reg;

        // A new timeout beats a simultaneous clear so the event is never lost.
        if (ack_timeout_set)
            err_next = 1'b1;
        else if (err_clr_i)
            err_next = 1'b0;
        else
            err_next = err_reg;

        throttle_next  = (state_reg == ST_ON) && (target_state_i == PWR_THERMAL_THROTTLE);
        wake_done_next = (state_reg == ST_GATED) && (state_next == ST_ON);
    end

    // State and counter registers with synchronous reset back to ON.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_ON;
            dwell_reg     <= '0;
            ack_cnt_reg   <= '0;
            err_reg       <= 1'b0;
            throttle_reg  <= 1'b0;
            wake_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dwell_reg     <= dwell_next;
            ack_cnt_reg   <= ack_cnt_next;
            err_reg       <= err_next;
            throttle_reg  <= throttle_next;
            wake_done_reg <= wake_done_next;
        end
    end

    // Moore decode of the physical controls from the current state.
    always_comb begin
        clk_en_o      = 1'b0;
        iso_en_o      = 1'b0;
        ret_save_o    = 1'b0;
        ret_restore_o = 1'b0;
        pwr_sw_en_o   = 1'b0;
        busy_o        = 1'b0;
        case (state_reg)
            ST_ON:      begin clk_en_o = 1'b1; pwr_sw_en_o = 1'b1; end
            ST_GATED:   begin pwr_sw_en_o = 1'b1; end
            ST_ISO:     begin iso_en_o = 1'b1; pwr_sw_en_o = 1'b1; busy_o = 1'b1; end
            ST_SAVE:    begin iso_en_o = 1'b1; ret_save_o = 1'b1; pwr_sw_en_o = 1'b1; busy_o = 1'b1; end
            ST_PSW_OFF: begin iso_en_o = 1'b1; busy_o = 1'b1; end
            ST_OFF:     begin iso_en_o = 1'b1; end
            ST_PSW_ON:  begin iso_en_o = 1'b1; pwr_sw_en_o = 1'b1; busy_o = 1'b1; end
            ST_RESTORE: begin iso_en_o = 1'b1; ret_restore_o = 1'b1; pwr_sw_en_o = 1'b1; busy_o = 1'b1; end
            ST_DEISO:   begin iso_en_o = 1'b1; pwr_sw_en_o = 1'b1; busy_o = 1'b1; end
            default:    begin clk_en_o = 1'b0; end
        endcase
    end

    assign throttle_o        = throttle_reg;
    assign wake_done_o       = wake_done_reg;
    assign ack_timeout_err_o = err_reg;
    assign seq_state_o       = state_reg;

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Directed bench for power_domain_sequencer: a cycle-by-cycle vector table for
// reset, clock gating and throttle, then hand-written deep-sleep sequences.

module tb_power_domain_sequencer;
    import power_domain_sequencer_pkg::*;

    localparam logic [3:0] S_ON = 4'd0, S_GATED = 4'd1, S_ISO = 4'd2, S_SAVE = 4'd3,
                           S_PSW_OFF = 4'd4, S_OFF = 4'd5, S_PSW_ON = 4'd6,
                           S_RESTORE = 4'd7, S_DEISO = 4'd8;

    logic         clk;
    logic         rst;
    power_state_t tgt;
    logic         ack;
    logic         clr;
    logic         clk_en, iso_en, ret_save, ret_restore, pwr_sw_en;
    logic         throttle, wake_done, busy, err;
    logic [3:0]   seq_state;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_err  = 1'b0;

    typedef struct {
        logic         rst;
        power_state_t tgt;
        logic         ack;
        logic         clr;
        logic [3:0]   st;
        logic         wake;
        logic         thr;
        logic         err;
    } vec_t;

    vec_t vecs[$];

    power_domain_sequencer #(
        .ISO_CYCLES(2), .SAVE_CYCLES(4), .RESTORE_CYCLES(4), .ACK_TIMEOUT(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .target_state_i(tgt), .pwr_sw_ack_i(ack),
        .err_clr_i(clr), .clk_en_o(clk_en), .iso_en_o(iso_en), .ret_save_o(ret_save),
        .ret_restore_o(ret_restore), .pwr_sw_en_o(pwr_sw_en), .throttle_o(throttle),
        .wake_done_o(wake_done), .busy_o(busy), .ack_timeout_err_o(err),
        .seq_state_o(seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {state, clk_en, iso, save, restore, psw, throttle, wake, busy, err}.
    function automatic logic [12:0] expv(logic [3:0] st, logic wk, logic thr, logic er);
        logic [4:0] f;
        logic       b;
        case (st)
            S_ON:      begin f = 5'b10001; b = 1'b0; end
            S_GATED:   begin f = 5'b00001; b = 1'b0; end
            S_ISO:     begin f = 5'b01001; b = 1'b1; end
            S_SAVE:    begin f = 5'b01101; b = 1'b1; end
            S_PSW_OFF: begin f = 5'b01000; b = 1'b1; end
            S_OFF:     begin f = 5'b01000; b = 1'b0; end
            S_PSW_ON:  begin f = 5'b01001; b = 1'b1; end
            S_RESTORE: begin f = 5'b01011; b = 1'b1; end
            default:   begin f = 5'b01001; b = 1'b1; end
        endcase
        return {st, f, thr, wk, b, er};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] st, input logic wk, input logic thr);
        logic [12:0] act;
        logic [12:0] exp;
        act = {seq_state, clk_en, iso_en, ret_save, ret_restore, pwr_sw_en,
               throttle, wake_done, busy, err};
        exp = expv(st, wk, thr, exp_err);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (st,clk,iso,sav,rst,psw,thr,wake,busy,err)",
                     name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    task automatic add(input logic r, input power_state_t t, input logic a, input logic c,
                       input logic [3:0] st, input logic wk, input logic thr, input logic er);
        vec_t v;
        v.rst = r; v.tgt = t; v.ack = a; v.clr = c;
        v.st = st; v.wake = wk; v.thr = thr; v.err = er;
        vecs.push_back(v);
    endtask

    // From ON with DEEP_SLEEP target: GATED, ISO x2, SAVE x4. save_tgt is applied after the first SAVE cycle.
    task automatic deep_to_save_end(input string tag, input power_state_t save_tgt);
        tgt = PWR_DEEP_SLEEP;
        tick(); chk({tag, "_gated"}, S_GATED, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin tick(); chk({tag, "_iso"}, S_ISO, 1'b0, 1'b0); end
        for (int i = 0; i < 4; i++) begin
            tick(); chk({tag, "_save"}, S_SAVE, 1'b0, 1'b0);
            tgt = save_tgt;
        end
    endtask

    // Finishes a wake-up: n_restore RESTORE cycles, DEISO x2, GATED, then ON with wake pulse.
    task automatic restore_to_on(input string tag, input int n_restore);
        for (int i = 0; i < n_restore; i++) begin tick(); chk({tag, "_restore"}, S_RESTORE, 1'b0, 1'b0); end
        for (int i = 0; i < 2; i++) begin tick(); chk({tag, "_deiso"}, S_DEISO, 1'b0, 1'b0); end
        tick(); chk({tag, "_gated"}, S_GATED, 1'b0, 1'b0);
        tick(); chk({tag, "_on_wake"}, S_ON, 1'b1, 1'b0);
        tick(); chk({tag, "_on"}, S_ON, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; tgt = PWR_ACTIVE; ack = 1'b1; clr = 1'b0;

        //   rst   target                ack   clr   state    wake  thr   err
        add(1'b1, PWR_ACTIVE,           1'b1, 1'b0, S_ON,    1'b0, 1'b0, 1'b0);
        add(1'b1, PWR_ACTIVE,           1'b1, 1'b0, S_ON,    1'b0, 1'b0, 1'b0);
        add(1'b0, PWR_ACTIVE,           1'b1, 1'b0, S_ON,    1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            add(1'b0, PWR_IDLE,         1'b1, 1'b0, S_GATED, 1'b0, 1'b0, 1'b0);
        add(1'b0, PWR_ACTIVE,           1'b1, 1'b0, S_ON,    1'b1, 1'b0, 1'b0);
        add(1'b0, PWR_ACTIVE,           1'b1, 1'b0, S_ON,    1'b0, 1'b0, 1'b0);
        add(1'b0, PWR_THERMAL_THROTTLE, 1'b1, 1'b0, S_ON,    1'b0, 1'b1, 1'b0);
        add(1'b0, PWR_THERMAL_THROTTLE, 1'b1, 1'b0, S_ON,    1'b0, 1'b1, 1'b0);
        add(1'b0, PWR_ACTIVE,           1'b1, 1'b0, S_ON,    1'b0, 1'b0, 1'b0);
        add(1'b0, PWR_SLEEP,            1'b1, 1'b0, S_GATED, 1'b0, 1'b0, 1'b0);
        add(1'b0, PWR_THERMAL_THROTTLE, 1'b1, 1'b0, S_ON,    1'b1, 1'b0, 1'b0);
        add(1'b0, PWR_THERMAL_THROTTLE, 1'b1, 1'b0, S_ON,    1'b0, 1'b1, 1'b0);
        add(1'b0, PWR_ACTIVE,           1'b1, 1'b0, S_ON,    1'b0, 1'b0, 1'b0);
        add(1'b0, PWR_ACTIVE,           1'b1, 1'b1, S_ON,    1'b0, 1'b0, 1'b0);
        add(1'b0, PWR_IDLE,             1'b1, 1'b0, S_GATED, 1'b0, 1'b0, 1'b0);
        add(1'b1, PWR_IDLE,             1'b1, 1'b0, S_ON,    1'b0, 1'b0, 1'b0);
        add(1'b0, PWR_ACTIVE,           1'b1, 1'b0, S_ON,    1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; tgt = vecs[i].tgt; ack = vecs[i].ack; clr = vecs[i].clr;
            exp_err = vecs[i].err;
            tick();
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].wake, vecs[i].thr);
        end
        rst = 1'b0; clr = 1'b0; exp_err = 1'b0;

        // Deep sleep entry; ack drops 3 cycles after the switch is released.
        deep_to_save_end("dsl", PWR_DEEP_SLEEP);
        for (int i = 0; i < 3; i++) begin tick(); chk("dsl_psw_off", S_PSW_OFF, 1'b0, 1'b0); end
        ack = 1'b0;
        tick(); chk("dsl_off", S_OFF, 1'b0, 1'b0);
        tick(); chk("dsl_off_hold", S_OFF, 1'b0, 1'b0);

        // Wake from OFF; ack rises after 5 PSW_ON cycles.
        tgt = PWR_ACTIVE;
        for (int i = 0; i < 5; i++) begin tick(); chk("wk_psw_on", S_PSW_ON, 1'b0, 1'b0); end
        ack = 1'b1;
        restore_to_on("wk", 4);

        // Target goes ACTIVE during SAVE: sequence still completes to OFF, then PSW_ON.
        deep_to_save_end("abt", PWR_ACTIVE);
        tick(); chk("abt_psw_off", S_PSW_OFF, 1'b0, 1'b0);
        ack = 1'b0;
        tick(); chk("abt_off", S_OFF, 1'b0, 1'b0);
        tick(); chk("abt_psw_on", S_PSW_ON, 1'b0, 1'b0);
        ack = 1'b1;
        restore_to_on("abt", 4);
        tgt = PWR_THERMAL_THROTTLE;
        tick(); chk("thr_on", S_ON, 1'b0, 1'b1);
        tgt = PWR_ACTIVE;
        tick(); chk("thr_off", S_ON, 1'b0, 1'b0);

        // Ack held high in PSW_OFF: timeout after 16 cycles.
        deep_to_save_end("to", PWR_DEEP_SLEEP);
        for (int i = 0; i < 16; i++) begin tick(); chk("to_psw_off", S_PSW_OFF, 1'b0, 1'b0); end
        exp_err = 1'b1;
        tick(); chk("to_off_err", S_OFF, 1'b0, 1'b0);
        tick(); chk("to_err_sticky", S_OFF, 1'b0, 1'b0);
        clr = 1'b1; exp_err = 1'b0;
        tick(); chk("to_err_clr", S_OFF, 1'b0, 1'b0);
        clr = 1'b0;

        // PSW_ON timeout with err_clr in the same cycle: set wins.
        ack = 1'b0; tgt = PWR_ACTIVE;
        for (int i = 0; i < 16; i++) begin tick(); chk("to_psw_on", S_PSW_ON, 1'b0, 1'b0); end
        clr = 1'b1; exp_err = 1'b1;
        tick(); chk("to_set_vs_clr", S_RESTORE, 1'b0, 1'b0);
        clr = 1'b0; ack = 1'b1;
        restore_to_on("to", 3);
        clr = 1'b1; exp_err = 1'b0;
        tick(); chk("to_clr2", S_ON, 1'b0, 1'b0);
        clr = 1'b0;

        // Ack arriving on the final wait cycle wins over the timeout.
        deep_to_save_end("edge", PWR_DEEP_SLEEP);
        for (int i = 0; i < 16; i++) begin tick(); chk("edge_psw_off", S_PSW_OFF, 1'b0, 1'b0); end
        ack = 1'b0;
        tick(); chk("edge_ack_wins", S_OFF, 1'b0, 1'b0);
        tgt = PWR_ACTIVE;
        tick(); chk("edge_psw_on", S_PSW_ON, 1'b0, 1'b0);
        tick(); chk("edge_psw_on2", S_PSW_ON, 1'b0, 1'b0);
        rst = 1'b1;
        tick(); chk("rst_mid_psw_on", S_ON, 1'b0, 1'b0);
        rst = 1'b0;
        tick(); chk("post_rst_on", S_ON, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
